// File: rtl/ext_int_ctrl_pkg.sv
// Shared constants for the external-interrupt controller.
// Register map, ACTIVE field layout and FSM encoding.
package int_ctrl_pkg;
  localparam int ENABLE_ADDR = 0;
  localparam int EDGE_ADDR   = 1;
  localparam int PEND_ADDR   = 2;
  localparam int ACTIVE_ADDR = 3;

  localparam int ACT_SVC_BIT = 4;
  localparam int ACT_ID_W    = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;
endpackage

// File: rtl/ext_int_ctrl_if.sv
// Coprocessor-side register port and interrupt request bundle.
// master = coprocessor, slave = interrupt controller.
interface ext_int_ctrl_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
);
  logic                      i_en;
  logic [REG_ADDR_WIDTH-1:0] i_address;
  logic [DATA_WIDTH-1:0]     i_din;
  logic                      i_int_taken;
  logic                      i_eret;
  logic [DATA_WIDTH-1:0]     o_dout;
  logic                      o_external_int;
  logic [3:0]                o_active_id;

  modport master (
    output i_en, i_address, i_din,
    output i_int_taken, i_eret,
    input  o_dout, o_external_int, o_active_id
  );

  modport slave (
    input  i_en, i_address, i_din,
    input  i_int_taken, i_eret,
    output o_dout, o_external_int, o_active_id
  );
endinterface

// File: rtl/ext_int_ctrl_sync.sv
// Per-line synchroniser with a rising-edge detector.
// o_rise is high for one cycle after the synced level goes 0->1.
module irq_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_arst_n,
  input  logic i_irq,
  output logic o_level,
  output logic o_rise
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_irq};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign o_level = sync_q[SYNC_STAGES-1];
  assign o_rise  = o_level & ~prev_q;
endmodule

// File: rtl/ext_int_ctrl.sv
// External-interrupt controller: sync, qualify, latch, prioritise,
// then hold one request until the coprocessor takes it and erets.
module ext_int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int NUM_IRQ        = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int SYNC_STAGES    = 2
) (
  input  logic               i_clk,
  input  logic               i_arst_n,
  input  logic [NUM_IRQ-1:0] i_irq,
  ext_int_ctrl_if.slave      bus
);
  logic [NUM_IRQ-1:0] level, rise;
  logic [NUM_IRQ-1:0] enable_q, edge_q;
  logic [NUM_IRQ-1:0] pend_q, pend_d;
  logic [NUM_IRQ-1:0] pending, eligible;
  logic [NUM_IRQ-1:0] wdata, w1c, edge_next;
  logic [NUM_IRQ-1:0] take_mask;
  logic [15:0]        take_oh, elig_ext;
  logic [3:0]         winner, active_id_q;
  logic               we_enable, we_edge, we_pend;
  logic               take, ext_int, in_svc;
  logic [DATA_WIDTH-1:0] rd_data, dout_q;
  logic               unused_din;
  state_t             state_q, state_d;

  for (genvar g = 0; g < NUM_IRQ; g++) begin : g_sync
    irq_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .i_clk    (i_clk),
      .i_arst_n (i_arst_n),
      .i_irq    (i_irq[g]),
      .o_level  (level[g]),
      .o_rise   (rise[g])
    );
  end

  assign wdata      = bus.i_din[NUM_IRQ-1:0];
  assign unused_din = ^bus.i_din;

  assign we_enable = bus.i_en &&
    bus.i_address == REG_ADDR_WIDTH'(ENABLE_ADDR);
  assign we_edge   = bus.i_en &&
    bus.i_address == REG_ADDR_WIDTH'(EDGE_ADDR);
  assign we_pend   = bus.i_en &&
    bus.i_address == REG_ADDR_WIDTH'(PEND_ADDR);

  assign take      = (state_q == REQ) && bus.i_int_taken;
  assign take_oh   = 16'(1) << active_id_q;
  assign take_mask = take ? take_oh[NUM_IRQ-1:0] : '0;
  assign w1c       = we_pend ? wdata : '0;
  assign edge_next = we_edge ? wdata : edge_q;

  // Set beats clear; masking with edge_next drops the latch on edge->level.
  assign pend_d   = ((pend_q & ~w1c & ~take_mask) | rise) & edge_next;
  assign pending  = pend_q | (level & ~edge_q);
  assign eligible = pending & enable_q;
  assign elig_ext = 16'(eligible);

  always_comb begin
    winner = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) winner = 4'(i);
    end
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      enable_q <= '0;
      edge_q   <= '0;
      pend_q   <= '0;
    end else begin
      if (we_enable) enable_q <= wdata;
      edge_q <= edge_next;
      pend_q <= pend_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state_q     <= IDLE;
      active_id_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && |eligible) active_id_q <= winner;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (|eligible) state_d = REQ;
      REQ: begin
        if (bus.i_int_taken)          state_d = SERVICE;
        else if (!elig_ext[active_id_q]) state_d = IDLE;
      end
      SERVICE: if (bus.i_eret) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ext_int = 1'b0;
    in_svc  = 1'b0;
    unique case (state_q)
      REQ:     ext_int = 1'b1;
      SERVICE: in_svc  = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    rd_data = '0;
    case (bus.i_address)
      REG_ADDR_WIDTH'(ENABLE_ADDR): rd_data = DATA_WIDTH'(enable_q);
      REG_ADDR_WIDTH'(EDGE_ADDR):   rd_data = DATA_WIDTH'(edge_q);
      REG_ADDR_WIDTH'(PEND_ADDR):   rd_data = DATA_WIDTH'(pending);
      REG_ADDR_WIDTH'(ACTIVE_ADDR):
        rd_data = DATA_WIDTH'({in_svc, active_id_q});
      default: rd_data = '0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) dout_q <= '0;
    else           dout_q <= rd_data;
  end

  assign bus.o_dout         = dout_q;
  assign bus.o_external_int = ext_int;
  assign bus.o_active_id    = active_id_q;
endmodule

// File: tb/tb_ext_int_ctrl.sv
// Directed bench for ext_int_ctrl: register table plus
// hand-written interrupt sequences with hand-computed expectations.
module tb_ext_int_ctrl;
  logic       clk;
  logic       rst_n;
  logic [7:0] irq;
  int         n_cmp;
  int         n_bad;

  ext_int_ctrl_if #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) bus ();

  ext_int_ctrl #(
    .NUM_IRQ(8), .DATA_WIDTH(32),
    .REG_ADDR_WIDTH(5), .SYNC_STAGES(2)
  ) dut (
    .i_clk    (clk),
    .i_arst_n (rst_n),
    .i_irq    (irq),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs [15];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string name, logic [31:0] act,
                       logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic wr(logic [4:0] a, logic [31:0] d);
    bus.i_en      = 1'b1;
    bus.i_address = a;
    bus.i_din     = d;
    tick();
    bus.i_en      = 1'b0;
    bus.i_din     = '0;
  endtask

  task automatic rd(logic [4:0] a, logic [31:0] exp, string name);
    bus.i_address = a;
    tick();
    check(name, bus.o_dout, exp);
  endtask

  task automatic pulse(logic [7:0] m);
    irq = m;
    tick();
    irq = '0;
  endtask

  task automatic take();
    bus.i_int_taken = 1'b1;
    tick();
    bus.i_int_taken = 1'b0;
  endtask

  task automatic eret();
    bus.i_eret = 1'b1;
    tick();
    bus.i_eret = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{1'b0, 5'd0, 32'h0, 32'h0, "rst_enable"};
    vecs[1]  = '{1'b0, 5'd1, 32'h0, 32'h0, "rst_edge"};
    vecs[2]  = '{1'b0, 5'd2, 32'h0, 32'h0, "rst_pend"};
    vecs[3]  = '{1'b0, 5'd3, 32'h0, 32'h0, "rst_active"};
    vecs[4]  = '{1'b1, 5'd0, 32'hFFFF_FF5A, 32'h0, "w_enable"};
    vecs[5]  = '{1'b0, 5'd0, 32'h0, 32'h5A, "rb_enable"};
    vecs[6]  = '{1'b1, 5'd1, 32'h0000_00A5, 32'h0, "w_edge"};
    vecs[7]  = '{1'b0, 5'd1, 32'h0, 32'hA5, "rb_edge"};
    vecs[8]  = '{1'b1, 5'd7, 32'hFFFF_FFFF, 32'h0, "w_unmapped"};
    vecs[9]  = '{1'b0, 5'd7, 32'h0, 32'h0, "rb_unmapped"};
    vecs[10] = '{1'b0, 5'd0, 32'h0, 32'h5A, "enable_kept"};
    vecs[11] = '{1'b1, 5'd2, 32'hFF, 32'h0, "w1c_empty"};
    vecs[12] = '{1'b0, 5'd2, 32'h0, 32'h0, "pend_empty"};
    vecs[13] = '{1'b1, 5'd0, 32'h04, 32'h0, "w_enable4"};
    vecs[14] = '{1'b1, 5'd1, 32'h04, 32'h0, "w_edge4"};

    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    irq   = '0;
    bus.i_en = 1'b0;
    bus.i_address = '0;
    bus.i_din = '0;
    bus.i_int_taken = 1'b0;
    bus.i_eret = 1'b0;
    repeat (2) tick();
    check("rst_ext", 32'(bus.o_external_int), 32'h0);
    check("rst_id", 32'(bus.o_active_id), 32'h0);
    check("rst_dout", bus.o_dout, 32'h0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 15; i++) begin
      if (vecs[i].we) wr(vecs[i].addr, vecs[i].data);
      else rd(vecs[i].addr, vecs[i].exp, vecs[i].name);
    end

    // basic edge request on line 2
    pulse(8'h04);
    tick();
    tick();
    check("lat_k2", 32'(bus.o_external_int), 32'h0);
    tick();
    check("lat_k3", 32'(bus.o_external_int), 32'h1);
    rd(5'd3, 32'h02, "active_req");
    take();
    check("taken_ext", 32'(bus.o_external_int), 32'h0);
    rd(5'd3, 32'h12, "active_svc");
    rd(5'd2, 32'h00, "pend_clr_take");
    eret();
    rd(5'd3, 32'h02, "active_idle");

    // simultaneous lines 5 and 1: lowest index first
    wr(5'd0, 32'hFF);
    wr(5'd1, 32'hFF);
    pulse(8'h22);
    repeat (3) tick();
    check("prio_ext", 32'(bus.o_external_int), 32'h1);
    check("prio_id1", 32'(bus.o_active_id), 32'h1);
    take();
    eret();
    check("gap_idle", 32'(bus.o_external_int), 32'h0);
    tick();
    check("prio_ext5", 32'(bus.o_external_int), 32'h1);
    check("prio_id5", 32'(bus.o_active_id), 32'h5);
    take();
    eret();

    // level line 3: withdraw in REQ, ignored in SERVICE
    wr(5'd1, 32'hF7);
    irq[3] = 1'b1;
    tick();
    tick();
    check("lvl_early", 32'(bus.o_external_int), 32'h0);
    tick();
    check("lvl_req", 32'(bus.o_external_int), 32'h1);
    check("lvl_id", 32'(bus.o_active_id), 32'h3);
    irq[3] = 1'b0;
    tick();
    tick();
    check("lvl_hold", 32'(bus.o_external_int), 32'h1);
    tick();
    check("lvl_withdraw", 32'(bus.o_external_int), 32'h0);
    tick();
    check("lvl_stay_idle", 32'(bus.o_external_int), 32'h0);
    irq[3] = 1'b1;
    repeat (3) tick();
    check("lvl_req2", 32'(bus.o_external_int), 32'h1);
    take();
    irq[3] = 1'b0;
    repeat (4) tick();
    check("lvl_svc_ext", 32'(bus.o_external_int), 32'h0);
    rd(5'd3, 32'h13, "lvl_svc_active");
    eret();
    repeat (2) tick();
    check("lvl_after_eret", 32'(bus.o_external_int), 32'h0);

    // W1C racing a new rise on line 0
    wr(5'd1, 32'hFF);
    pulse(8'h01);
    repeat (3) tick();
    check("e0_req", 32'(bus.o_external_int), 32'h1);
    check("e0_id", 32'(bus.o_active_id), 32'h0);
    irq[0] = 1'b1;
    tick();
    irq[0] = 1'b0;
    tick();
    wr(5'd2, 32'h01);
    rd(5'd2, 32'h01, "set_wins");
    check("set_wins_ext", 32'(bus.o_external_int), 32'h1);
    wr(5'd2, 32'h01);
    tick();
    check("w1c_withdraw", 32'(bus.o_external_int), 32'h0);
    rd(5'd2, 32'h00, "w1c_pend");

    // arrival during SERVICE waits for eret
    pulse(8'h10);
    repeat (3) tick();
    check("svc4_id", 32'(bus.o_active_id), 32'h4);
    take();
    pulse(8'h01);
    repeat (3) tick();
    check("svc_no_req", 32'(bus.o_external_int), 32'h0);
    rd(5'd2, 32'h01, "svc_pend0");
    eret();
    tick();
    check("eret_req0", 32'(bus.o_external_int), 32'h1);
    check("eret_id0", 32'(bus.o_active_id), 32'h0);

    // async reset in REQ
    take();
    eret();
    pulse(8'h40);
    repeat (3) tick();
    rd(5'd2, 32'h40, "pre_rst_pend");
    check("pre_rst_ext", 32'(bus.o_external_int), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_ext", 32'(bus.o_external_int), 32'h0);
    check("arst_dout", bus.o_dout, 32'h0);
    check("arst_id", 32'(bus.o_active_id), 32'h0);
    #3;
    rst_n = 1'b1;
    rd(5'd2, 32'h00, "post_rst_pend");
    rd(5'd0, 32'h00, "post_rst_enable");

    // edge->level switch discards a latched bit
    wr(5'd1, 32'hFF);
    pulse(8'h80);
    repeat (3) tick();
    rd(5'd2, 32'h80, "dis_pend7");
    check("dis_no_req", 32'(bus.o_external_int), 32'h0);
    wr(5'd1, 32'h7F);
    rd(5'd2, 32'h00, "edge2lvl_discard");

    wr(5'd0, 32'hFF);
    wr(5'd1, 32'hFF);
    repeat (4) tick();
    check("no_req_no_edge", 32'(bus.o_external_int), 32'h0);
    pulse(8'h40);
    repeat (3) tick();
    check("new_edge_req", 32'(bus.o_external_int), 32'h1);
    check("new_edge_id", 32'(bus.o_active_id), 32'h6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
